datapath_controller: RTL and testbench

//  Control stage directly upstream of the computation stage (shifter/ALU/status/C).

---
 rtl/datapath_controller_pkg.sv | 34 +++
 rtl/datapath_controller_dff.sv | 23 ++
 rtl/datapath_controller.sv | 156 +++++++++++++++
 tb/tb_datapath_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the datapath controller: widths, instruction field codes, state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package datapath_controller_pkg;

    localparam int DP_WIDTH   = 16;
    localparam int DP_REGADDR = 3;

    // Instruction classes (IR[15:13]) and sub-ops (IR[12:11])
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;

    // ALU operation codes; ALU-class instructions pass op straight through
    localparam logic [1:0] ALU_ADD = 2'b00;

    // Writeback source select
    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

    // Binary encoding; 3'b111 is unused and recovers to ST_WAIT
    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_COMPUTE   = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_t;

endpackage

// File: rtl/datapath_controller_dff.sv
// Enable flop with async active-low clear; holds the instruction register.
// Latency: 1 cycle from d/en to q.
// Backpressure: none; en gates capture.
// Ports: clk, rst_n, en (capture enable), d (next value), q (held value).
module DFlipFlopAllow #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath_controller.sv
// Instruction register plus Moore sequencer driving register file, A/B/C/status loads and ALU.
// Latency: s->done is 2 (MOV imm), 4 (MOV reg, CMP), 5 (ADD/AND/MVN) cycles.
// Backpressure: one instruction at a time; s/load_ir only honoured while w=1.
// Ports: clk, rst_n | s, load_ir, instr_in | w, done, illegal | readnum, writenum, write,
//        vsel, sximm8 | loada, loadb, asel, bsel, shift, ALUop, loadc, loads.
module datapath_controller
    import datapath_controller_pkg::*;
#(
    parameter int WIDTH   = DP_WIDTH,
    parameter int REGADDR = DP_REGADDR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s,
    input  logic               load_ir,
    input  logic [WIDTH-1:0]   instr_in,
    output logic               w,
    output logic               done,
    output logic               illegal,
    output logic [REGADDR-1:0] readnum,
    output logic [REGADDR-1:0] writenum,
    output logic               write,
    output logic               vsel,
    output logic [WIDTH-1:0]   sximm8,
    output logic               loada,
    output logic               loadb,
    output logic               asel,
    output logic               bsel,
    output logic [1:0]         shift,
    output logic [1:0]         ALUop,
    output logic               loadc,
    output logic               loads
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   ir;
    logic [2:0]         opcode;
    logic [1:0]         op;
    logic [REGADDR-1:0] rn, rd, rm;
    logic [1:0]         sh;
    logic               is_mov, is_mov_imm, is_mov_reg, is_alu, is_cmp, is_legal;

    // IR only captures while idle, so it stays stable across an instruction.
    DFlipFlopAllow #(.WIDTH(WIDTH)) u_ir (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (load_ir & w),
        .d     (instr_in),
        .q     (ir)
    );

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

    assign is_mov     = (opcode == OPC_MOV);
    assign is_mov_imm = is_mov && (op == OP_MOV_IMM);
    assign is_mov_reg = is_mov && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

    // State register; illegal flag is set by DECODE and cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_WAIT;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_WAIT && s) begin
                illegal <= 1'b0;
            end else if (state == ST_DECODE && !is_legal) begin
                illegal <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = ST_WAIT;
        case (state)
            ST_WAIT:      state_nxt = s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                if (is_mov_imm)      state_nxt = ST_WRITE_IMM;
                else if (is_mov_reg) state_nxt = ST_GET_B;     // MOV reg needs no A operand
                else if (is_alu)     state_nxt = ST_GET_A;
                else                 state_nxt = ST_WAIT;
            end
            ST_WRITE_IMM: state_nxt = ST_WAIT;
            ST_GET_A:     state_nxt = ST_GET_B;
            ST_GET_B:     state_nxt = ST_COMPUTE;
            ST_COMPUTE:   state_nxt = is_cmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_nxt = ST_WAIT;
            default:      state_nxt = ST_WAIT;
        endcase
    end

    // Moore outputs: functions of state and IR only
    always_comb begin
        w        = 1'b0;
        done     = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = VSEL_C;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        loadc    = 1'b0;
        loads    = 1'b0;
        case (state)
            ST_WAIT: w = 1'b1;
            ST_WRITE_IMM: begin
                writenum = rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
                done     = 1'b1;
            end
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_COMPUTE: begin
                shift = sh;
                // MOV reg is computed as 0 + shifted B
                asel  = !is_mov;
                ALUop = is_mov ? ALU_ADD : op;
                if (is_cmp) begin
                    loads = 1'b1;
                    done  = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                writenum = rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: vector table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_datapath_controller;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic        load_ir;
    logic [15:0] instr_in;
    logic        w, done, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm8;
    logic [1:0]  shift, ALUop;

    datapath_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .load_ir  (load_ir),
        .instr_in (instr_in),
        .w        (w),
        .done     (done),
        .illegal  (illegal),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .sximm8   (sximm8),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic        done;
        logic        illegal;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        vsel;
        logic [15:0] sximm8;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        int          lat;       // s->done cycles, 0 = illegal (no done)
        logic        d_write;
        logic [2:0]  d_writenum;
        logic        d_loads;
        int          n_loada;
        logic [1:0]  c_alu;
        logic        c_asel;
        logic [1:0]  c_shift;
        logic        ill;
    } vec_t;

    int   checks;
    int   failures;
    obs_t exp_q[$];

    function automatic obs_t sample();
        obs_t o;
        o.w = w; o.done = done; o.illegal = illegal; o.readnum = readnum;
        o.writenum = writenum; o.write = write; o.vsel = vsel; o.sximm8 = sximm8;
        o.loada = loada; o.loadb = loadb; o.asel = asel; o.bsel = bsel;
        o.shift = shift; o.aluop = ALUop; o.loadc = loadc; o.loads = loads;
        return o;
    endfunction

    function automatic logic [15:0] sext8(input logic [15:0] ir);
        logic [15:0] v;
        v = {8'h00, ir[7:0]};
        if (ir[7]) v = v - 16'h0100;
        return v;
    endfunction

    function automatic obs_t idle_obs(input logic [15:0] ir, input logic ill);
        obs_t o;
        o = '0;
        o.w = 1'b1;
        o.illegal = ill;
        o.sximm8 = sext8(ir);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present instruction with load_ir and s together; returns in cycle 1 (decode).
    task automatic issue(input logic [15:0] instr);
        instr_in = instr;
        load_ir  = 1'b1;
        s        = 1'b1;
        step();
        load_ir  = 1'b0;
        s        = 1'b0;
    endtask

    // Reference trace: expected outputs for each cycle after s, ending with the idle cycle.
    task automatic build_trace(input logic [15:0] ir);
        obs_t b, t;
        logic [2:0] opc;
        logic [1:0] op;
        logic mov_imm, mov_reg, alu, cmp;
        opc = ir[15:13];
        op  = ir[12:11];
        mov_imm = (opc == 3'b110) && (op == 2'b10);
        mov_reg = (opc == 3'b110) && (op == 2'b00);
        alu     = (opc == 3'b101);
        cmp     = alu && (op == 2'b01);
        b = '0;
        b.sximm8 = sext8(ir);
        exp_q.delete();
        exp_q.push_back(b);
        if (!(mov_imm || mov_reg || alu)) begin
            t = b; t.w = 1'b1; t.illegal = 1'b1;
            exp_q.push_back(t);
            return;
        end
        if (mov_imm) begin
            t = b; t.writenum = ir[10:8]; t.vsel = 1'b1; t.write = 1'b1; t.done = 1'b1;
            exp_q.push_back(t);
        end else begin
            if (alu) begin
                t = b; t.readnum = ir[10:8]; t.loada = 1'b1;
                exp_q.push_back(t);
            end
            t = b; t.readnum = ir[2:0]; t.loadb = 1'b1;
            exp_q.push_back(t);
            t = b; t.shift = ir[4:3]; t.asel = alu; t.aluop = alu ? op : 2'b00;
            if (cmp) begin t.loads = 1'b1; t.done = 1'b1; end
            else     t.loadc = 1'b1;
            exp_q.push_back(t);
            if (!cmp) begin
                t = b; t.writenum = ir[7:5]; t.write = 1'b1; t.done = 1'b1;
                exp_q.push_back(t);
            end
        end
        t = b; t.w = 1'b1;
        exp_q.push_back(t);
    endtask

    initial begin
        vec_t        vecs[8];
        obs_t        o;
        int          lat, exit_c, na;
        logic        d_wr, d_lds;
        logic [2:0]  d_wn;
        logic [1:0]  c_alu, c_sh;
        logic        c_asel;
        logic [15:0] m_ir;
        logic        m_ill;

        checks = 0;
        failures = 0;
        vecs[0] = '{16'hD1F0, 2, 1'b1, 3'd1, 1'b0, 0, 2'b00, 1'b0, 2'b00, 1'b0};
        vecs[1] = '{16'hA148, 5, 1'b1, 3'd2, 1'b0, 1, 2'b00, 1'b1, 2'b01, 1'b0};
        vecs[2] = '{16'hA900, 4, 1'b0, 3'd0, 1'b1, 1, 2'b01, 1'b1, 2'b00, 1'b0};
        vecs[3] = '{16'hC0B6, 4, 1'b1, 3'd5, 1'b0, 0, 2'b00, 1'b0, 2'b10, 1'b0};
        vecs[4] = '{16'hB2E5, 5, 1'b1, 3'd7, 1'b0, 1, 2'b10, 1'b1, 2'b00, 1'b0};
        vecs[5] = '{16'hB864, 5, 1'b1, 3'd3, 1'b0, 1, 2'b11, 1'b1, 2'b00, 1'b0};
        vecs[6] = '{16'hE000, 0, 1'b0, 3'd0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 1'b1};
        vecs[7] = '{16'hC800, 0, 1'b0, 3'd0, 1'b0, 0, 2'b00, 1'b0, 2'b00, 1'b1};

        rst_n = 1'b0; s = 1'b0; load_ir = 1'b0; instr_in = 16'h0000;
        #12;
        chk_obs("reset_state", sample(), idle_obs(16'h0000, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Vector table
        foreach (vecs[k]) begin
            issue(vecs[k].instr);
            lat = 0; exit_c = 0; na = 0;
            d_wr = 1'b0; d_wn = '0; d_lds = 1'b0;
            c_alu = '0; c_sh = '0; c_asel = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                o = sample();
                if (o.loada) na++;
                if (o.loadc || o.loads) begin
                    c_alu = o.aluop; c_sh = o.shift; c_asel = o.asel;
                end
                if (o.done && lat == 0) begin
                    lat = c; d_wr = o.write; d_wn = o.writenum; d_lds = o.loads;
                end
                if (o.w) begin
                    exit_c = c;
                    break;
                end
                step();
            end
            chk($sformatf("vec%0d_latency", k), lat, vecs[k].lat);
            chk($sformatf("vec%0d_wait_cycle", k), exit_c, (vecs[k].lat == 0) ? 2 : vecs[k].lat + 1);
            chk($sformatf("vec%0d_illegal", k), o.illegal, vecs[k].ill);
            chk($sformatf("vec%0d_loada_count", k), na, vecs[k].n_loada);
            chk($sformatf("vec%0d_sximm8", k), o.sximm8, sext8(vecs[k].instr));
            if (vecs[k].lat != 0) begin
                chk($sformatf("vec%0d_done_write", k), d_wr, vecs[k].d_write);
                chk($sformatf("vec%0d_done_writenum", k), d_wn, vecs[k].d_writenum);
                chk($sformatf("vec%0d_done_loads", k), d_lds, vecs[k].d_loads);
            end
            if (vecs[k].lat >= 4) begin
                chk($sformatf("vec%0d_aluop", k), c_alu, vecs[k].c_alu);
                chk($sformatf("vec%0d_shift", k), c_sh, vecs[k].c_shift);
                chk($sformatf("vec%0d_asel", k), c_asel, vecs[k].c_asel);
            end
        end

        // Asynchronous reset while in GET_B
        issue(16'hA148);
        step();
        step();
        chk("getb_loadb", loadb, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_w", w, 1'b1);
        chk("rst_mid_write", write, 1'b0);
        chk("rst_mid_loadc", loadc, 1'b0);
        chk("rst_mid_loads", loads, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_obs("post_rst_idle", sample(), idle_obs(16'h0000, 1'b0));
        end

        // Illegal flag set, then cleared by the next start; inputs toggled during execution
        issue(16'hE000);
        step();
        chk("ill_set", illegal, 1'b1);
        chk("ill_w", w, 1'b1);
        chk("ill_done", done, 1'b0);
        issue(16'hB864);
        chk("ill_cleared", illegal, 1'b0);
        s = 1'b1; load_ir = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) chk("tog_aluop", ALUop, 2'b11);
            if (c == 5) begin
                chk("tog_writenum", writenum, 3'd3);
                chk("tog_done", done, 1'b1);
            end
            s = ~s; load_ir = ~load_ir; instr_in = 16'($urandom);
            step();
        end
        chk("tog_back_wait", w, 1'b1);
        chk("tog_ir_stable", sximm8, 16'h0064);
        s = 1'b0; load_ir = 1'b0;
        m_ir = 16'hB864;
        m_ill = 1'b0;

        // Random instructions against the reference trace
        for (int n = 0; n < 150; n++) begin
            logic [15:0] ins;
            logic        ld;
            logic [15:0] val;
            int          gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                val = 16'($urandom);
                ld  = 1'($urandom_range(0, 1));
                instr_in = val; load_ir = ld; s = 1'b0;
                step();
                if (ld) m_ir = val;
                chk_obs("rand_idle", sample(), idle_obs(m_ir, m_ill));
            end
            case ($urandom_range(0, 3))
                0:       ins = {3'b110, 13'($urandom)};
                1, 2:    ins = {3'b101, 13'($urandom)};
                default: ins = 16'($urandom);
            endcase
            build_trace(ins);
            issue(ins);
            m_ir = ins;
            for (int i = 0; i < exp_q.size(); i++) begin
                chk_obs("rand_cycle", sample(), exp_q[i]);
                if (i == exp_q.size() - 1) begin
                    s = 1'b0; load_ir = 1'b0;
                end else begin
                    s = 1'($urandom_range(0, 1));
                    load_ir = 1'($urandom_range(0, 1));
                    instr_in = 16'($urandom);
                    step();
                end
            end
            m_ill = exp_q[exp_q.size() - 1].illegal;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
